// File: rtl/ysyx_23060332_lsu_pkg.sv
// rtl/ysyx_23060332_lsu_pkg.sv - shared size, address-window and state encodings for the LSU
package ysyx_23060332_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [31:0] LSU_MEM_LO = 32'h8000_0000;
    localparam logic [31:0] LSU_MEM_HI = 32'h87ff_ffff;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_align.sv
// rtl/ysyx_23060332_lsu_align.sv - combinational lane shift, strobe generation and load extension
module ysyx_23060332_lsu_align
    import ysyx_23060332_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NB     = DATA_W / 8,
    parameter int OFF_W  = $clog2(NB)
) (
    input  logic [DATA_W-1:0] wdata,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [DATA_W-1:0] rdata_lo,
    input  logic [DATA_W-1:0] rdata_hi,
    output logic [DATA_W-1:0] wdata_lo,
    output logic [DATA_W-1:0] wdata_hi,
    output logic [NB-1:0]     wstrb_lo,
    output logic [NB-1:0]     wstrb_hi,
    output logic [DATA_W-1:0] ldata
);

    localparam int SW = 2 * NB;

    logic [2*DATA_W-1:0] shifted;
    logic [2*DATA_W-1:0] assembled;
    logic [SW-1:0]       strb2;
    logic [DATA_W-1:0]   a;
    logic                sign;

    always_comb begin
        shifted   = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
        strb2     = ((SW'(1) << size_bytes(size)) - SW'(1)) << off;
        assembled = {rdata_hi, rdata_lo} >> {off, 3'b000};
        a         = assembled[DATA_W-1:0];
        case (size)
            SZ_B:    sign = a[7];
            SZ_H:    sign = a[15];
            SZ_W:    sign = a[31];
            default: sign = a[DATA_W-1];
        endcase
        ldata = '0;
        // Bits above the access width are filled with the sign bit unless zero-extending.
        for (int i = 0; i < DATA_W; i++) begin
            ldata[i] = (i < (8 << size)) ? a[i] : (!uns && sign);
        end
    end

    assign wdata_lo = shifted[DATA_W-1:0];
    assign wdata_hi = shifted[2*DATA_W-1:DATA_W];
    assign wstrb_lo = strb2[NB-1:0];
    assign wstrb_hi = strb2[SW-1:NB];

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// rtl/ysyx_23060332_lsu.sv - load/store unit: request capture, one or two memory beats, response hold
module ysyx_23060332_lsu
    import ysyx_23060332_lsu_pkg::*;
#(
    parameter int              DATA_W = 32,
    parameter int              ADDR_W = 32,
    parameter logic [ADDR_W-1:0] MEM_LO = ADDR_W'(LSU_MEM_LO),
    parameter logic [ADDR_W-1:0] MEM_HI = ADDR_W'(LSU_MEM_HI)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int AW1   = ADDR_W + 1;

    lsu_state_e        state_q, state_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [AW1-1:0]    req_last;
    logic              req_fault;
    logic [OFF_W-1:0]  off;
    logic              split;
    logic [ADDR_W-1:0] beat_base;

    logic [DATA_W-1:0] al_rlo;
    logic [DATA_W-1:0] al_wdata_lo, al_wdata_hi, al_ldata;
    logic [NB-1:0]     al_wstrb_lo, al_wstrb_hi;

    // Last byte computed one bit wider so an access running past the top of the address space still faults.
    assign req_last  = {1'b0, req_addr} + AW1'(size_bytes(req_size)) - AW1'(1);
    assign req_fault = (req_addr < MEM_LO) || (req_last > {1'b0, MEM_HI}) ||
                       (int'(size_bytes(req_size)) > NB);

    assign off       = addr_q[OFF_W-1:0];
    assign split     = (int'(off) + int'(size_bytes(size_q))) > NB;
    assign beat_base = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign al_rlo    = (state_q == ST_BEAT1) ? rdata0_q : mem_rdata;

    ysyx_23060332_lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .wdata    (wdata_q),
        .off      (off),
        .size     (size_q),
        .uns      (uns_q),
        .rdata_lo (al_rlo),
        .rdata_hi (mem_rdata),
        .wdata_lo (al_wdata_lo),
        .wdata_hi (al_wdata_hi),
        .wstrb_lo (al_wstrb_lo),
        .wstrb_hi (al_wstrb_hi),
        .ldata    (al_ldata)
    );

    always_comb begin
        state_d      = state_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        rdata0_d     = rdata0_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        req_ready    = 1'b0;
        mem_valid    = 1'b0;
        mem_wen      = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wen_d        = req_wen;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    size_d       = req_size;
                    uns_d        = req_unsigned;
                    resp_rdata_d = '0;
                    resp_err_d   = req_fault;
                    state_d      = req_fault ? ST_RESP : ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                mem_valid = 1'b1;
                mem_wen   = wen_q;
                mem_addr  = beat_base;
                mem_wdata = al_wdata_lo;
                mem_wstrb = al_wstrb_lo;
                if (mem_ready) begin
                    rdata0_d = mem_rdata;
                    if (split) begin
                        state_d = ST_BEAT1;
                    end else begin
                        state_d      = ST_RESP;
                        resp_rdata_d = wen_q ? '0 : al_ldata;
                    end
                end
            end
            ST_BEAT1: begin
                mem_valid = 1'b1;
                mem_wen   = wen_q;
                mem_addr  = beat_base + ADDR_W'(NB);
                mem_wdata = al_wdata_hi;
                mem_wstrb = al_wstrb_hi;
                if (mem_ready) begin
                    state_d      = ST_RESP;
                    resp_rdata_d = wen_q ? '0 : al_ldata;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_valid && resp_err_q;
    assign resp_rdata = resp_valid ? resp_rdata_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            rdata0_q     <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            rdata0_q     <= rdata0_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// tb/tb_ysyx_23060332_lsu.sv - directed self-checking bench for the LSU
module tb_ysyx_23060332_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    ysyx_23060332_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b1; mem_ready = 1'b1; mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);

        // aligned word load, 2-cycle latency
        mem_rdata = 32'h8bad_f00d;
        issue(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0);
        chk("lw_mem_valid", mem_valid, 1);
        chk("lw_mem_addr", mem_addr, 32'h8000_0000);
        chk("lw_mem_wen", mem_wen, 0);
        chk("lw_req_ready_busy", req_ready, 0);
        chk("lw_resp_early", resp_valid, 0);
        @(negedge clk);
        chk("lw_resp_valid", resp_valid, 1);
        chk("lw_resp_rdata", resp_rdata, 32'h8bad_f00d);
        chk("lw_resp_err", resp_err, 0);
        chk("lw_mem_valid_resp", mem_valid, 0);
        @(negedge clk);
        chk("lw_idle_resp", resp_valid, 0);
        chk("lw_idle_ready", req_ready, 1);

        // signed and unsigned byte loads at offset 3
        mem_rdata = 32'h8011_2233;
        issue(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0);
        chk("lb_mem_addr", mem_addr, 32'h8000_0000);
        @(negedge clk);
        chk("lb_rdata", resp_rdata, 32'hffff_ff80);
        @(negedge clk);
        issue(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1);
        @(negedge clk);
        chk("lbu_rdata", resp_rdata, 32'h0000_0080);
        @(negedge clk);

        // split word store with beat1 stalls and response backpressure
        issue(1'b1, 32'h8000_0002, 32'h1122_3344, 2'd2, 1'b0);
        chk("sw_b0_valid", mem_valid, 1);
        chk("sw_b0_wen", mem_wen, 1);
        chk("sw_b0_addr", mem_addr, 32'h8000_0000);
        chk("sw_b0_wdata", mem_wdata, 32'h3344_0000);
        chk("sw_b0_wstrb", mem_wstrb, 4'b1100);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("sw_b1_valid", mem_valid, 1);
            chk("sw_b1_addr", mem_addr, 32'h8000_0004);
            chk("sw_b1_wdata", mem_wdata, 32'h0000_1122);
            chk("sw_b1_wstrb", mem_wstrb, 4'b0011);
            chk("sw_b1_noresp", resp_valid, 0);
            @(negedge clk);
        end
        chk("sw_b1_still_valid", mem_valid, 1);
        chk("sw_b1_addr_held", mem_addr, 32'h8000_0004);
        mem_ready  = 1'b1;
        resp_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("sw_resp_valid", resp_valid, 1);
            chk("sw_resp_rdata", resp_rdata, 0);
            chk("sw_resp_err", resp_err, 0);
            chk("sw_resp_memidle", mem_valid, 0);
            chk("sw_resp_busy", req_ready, 0);
            if (i == 1) resp_ready = 1'b1;
            @(negedge clk);
        end
        chk("sw_done_resp", resp_valid, 0);
        chk("sw_done_ready", req_ready, 1);

        // address faults: no beat, one-cycle latency
        issue(1'b0, 32'h87ff_fffe, 32'h0, 2'd2, 1'b0);
        chk("f_hi_memvalid", mem_valid, 0);
        chk("f_hi_resp", resp_valid, 1);
        chk("f_hi_err", resp_err, 1);
        chk("f_hi_rdata", resp_rdata, 0);
        @(negedge clk);
        issue(1'b0, 32'h7fff_fffc, 32'h0, 2'd2, 1'b0);
        chk("f_lo_memvalid", mem_valid, 0);
        chk("f_lo_resp", resp_valid, 1);
        chk("f_lo_err", resp_err, 1);
        @(negedge clk);
        issue(1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0);
        chk("f_dw_err", resp_err, 1);
        chk("f_dw_memvalid", mem_valid, 0);
        @(negedge clk);
        issue(1'b0, 32'h87ff_fffc, 32'h0, 2'd2, 1'b0);
        chk("top_word_ok", mem_valid, 1);
        @(negedge clk);
        chk("top_word_noerr", resp_err, 0);
        @(negedge clk);

        // split signed halfword load, 3-cycle latency
        mem_rdata = 32'haa00_0000;
        issue(1'b0, 32'h8000_0003, 32'h0, 2'd1, 1'b0);
        chk("lh_b0_addr", mem_addr, 32'h8000_0000);
        @(negedge clk);
        chk("lh_b1_addr", mem_addr, 32'h8000_0004);
        chk("lh_b1_noresp", resp_valid, 0);
        mem_rdata = 32'h0000_00bb;
        @(negedge clk);
        chk("lh_resp_valid", resp_valid, 1);
        chk("lh_rdata", resp_rdata, 32'hffff_bbaa);
        @(negedge clk);

        // byte store at offset 1
        issue(1'b1, 32'h8000_0001, 32'h0000_00ab, 2'd0, 1'b0);
        chk("sb_wdata", mem_wdata, 32'h0000_ab00);
        chk("sb_wstrb", mem_wstrb, 4'b0010);
        @(negedge clk);
        chk("sb_resp", resp_valid, 1);
        @(negedge clk);

        // reset in the middle of a beat aborts the access
        mem_ready = 1'b0;
        issue(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0);
        chk("ab_mem_valid", mem_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ab_mem_drop", mem_valid, 0);
        chk("ab_resp", resp_valid, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ab_no_resp", resp_valid, 0);
            chk("ab_no_beat", mem_valid, 0);
        end
        chk("ab_ready", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
